pwm_audio_decoder: RTL and testbench

PWM_AUDIO_DECODER -- requirements
Module: pwm_audio_decoder

---
 rtl/pwm_audio_decoder_pkg.sv | 20 ++
 rtl/pwm_audio_decoder_if.sv | 11 +
 rtl/pwm_window_integrator.sv | 47 ++++
 rtl/pwm_audio_decoder.sv | 168 ++++++++++++++++
 tb/tb_pwm_audio_decoder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_audio_decoder_pkg.sv
// Shared constants for the PWM audio decoder: activity FSM encoding,
// period width and a saturating counter helper.
package pwm_audio_decoder_pkg;

    localparam int PERIOD_W = 16;

    localparam logic [0:0] ST_SILENT = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_audio_decoder_if.sv
// Sample handshake bundle between the decoder (master) and its consumer (slave).
interface pwm_audio_decoder_if #(
    parameter int WIN_BITS = 8
);
    logic [WIN_BITS-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_window_integrator.sv
// Counts high cycles of the synchronized PWM bit over 2^WIN_BITS-cycle windows
// and presents a saturated total on the wrap cycle.
module pwm_window_integrator #(
    parameter int WIN_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s,
    output logic                capture,
    output logic [WIN_BITS-1:0] capture_value
);

    localparam logic [WIN_BITS-1:0] CNT_ONE = {{(WIN_BITS-1){1'b0}}, 1'b1};
    localparam logic [WIN_BITS-1:0] CNT_MAX = {WIN_BITS{1'b1}};

    logic [WIN_BITS-1:0] win_cnt_r;
    logic [WIN_BITS:0]   acc_r;
    logic [WIN_BITS:0]   total_s;

    assign total_s = acc_r + {{WIN_BITS{1'b0}}, s};
    assign capture = (win_cnt_r == CNT_MAX);

    // A full window of ones overflows the sample width, so clamp it.
    always_comb begin
        if (total_s[WIN_BITS]) begin
            capture_value = CNT_MAX;
        end else begin
            capture_value = total_s[WIN_BITS-1:0];
        end
    end

    // Window counter and accumulator; the wrap cycle's bit is in the capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_r <= {WIN_BITS{1'b0}};
            acc_r     <= {(WIN_BITS+1){1'b0}};
        end else begin
            win_cnt_r <= win_cnt_r + CNT_ONE;
            if (capture) begin
                acc_r <= {(WIN_BITS+1){1'b0}};
            end else begin
                acc_r <= total_s;
            end
        end
    end

endmodule

// File: rtl/pwm_audio_decoder.sv
// PWM audio demodulator: windowed duty-cycle samples with valid/ready handshake,
// overrun flag and silence detection. Define PWM_DEC_PERIOD_EN for edge-period measurement.
module pwm_audio_decoder
    import pwm_audio_decoder_pkg::*;
#(
    parameter int WIN_BITS        = 8,
    parameter int SILENCE_WINDOWS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sound,
    pwm_audio_decoder_if.master aud,
    output logic                overrun,
    output logic                silent,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam logic [7:0] SILENCE_TH = 8'(SILENCE_WINDOWS);

    logic                sync1_r;
    logic                s_r;
    logic                capture_s;
    logic [WIN_BITS-1:0] capture_value_s;
    logic [WIN_BITS-1:0] sample_r;
    logic                sample_valid_r;
    logic                overrun_r;
    logic                handshake_s;
    logic [0:0]          state_r;
    logic [0:0]          state_next_s;
    logic [7:0]          zero_cnt_r;
    logic [7:0]          zero_cnt_next_s;
    logic                silent_r;

    // Two-flop synchronizer for the asynchronous PWM pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            s_r     <= 1'b0;
        end else begin
            sync1_r <= sound;
            s_r     <= sync1_r;
        end
    end

    pwm_window_integrator #(
        .WIN_BITS(WIN_BITS)
    ) u_integrator (
        .clk          (clk),
        .reset        (reset),
        .s            (s_r),
        .capture      (capture_s),
        .capture_value(capture_value_s)
    );

    assign handshake_s      = sample_valid_r & aud.sample_ready;
    assign aud.sample       = sample_r;
    assign aud.sample_valid = sample_valid_r;
    assign overrun          = overrun_r;
    assign silent           = silent_r;

    // Output holding register; a capture always wins over a pending sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_r       <= {WIN_BITS{1'b0}};
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (capture_s) begin
            sample_r       <= capture_value_s;
            sample_valid_r <= 1'b1;
            if (sample_valid_r && !aud.sample_ready) begin
                overrun_r <= 1'b1;
            end else if (handshake_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (handshake_s) begin
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            sample_valid_r <= sample_valid_r;
            overrun_r      <= overrun_r;
        end
    end

    // Activity FSM next state, evaluated on each capture.
    always_comb begin
        state_next_s    = state_r;
        zero_cnt_next_s = zero_cnt_r;
        if (capture_s) begin
            if (capture_value_s != {WIN_BITS{1'b0}}) begin
                state_next_s    = ST_ACTIVE;
                zero_cnt_next_s = 8'd0;
            end else begin
                zero_cnt_next_s = sat_inc8(zero_cnt_r);
                if (zero_cnt_next_s >= SILENCE_TH) begin
                    state_next_s = ST_SILENT;
                end else begin
                    state_next_s = state_r;
                end
            end
        end else begin
            state_next_s    = state_r;
            zero_cnt_next_s = zero_cnt_r;
        end
    end

    // Activity FSM state with silent registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_SILENT;
            zero_cnt_r <= 8'd0;
            silent_r   <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            zero_cnt_r <= zero_cnt_next_s;
            silent_r   <= (state_next_s == ST_SILENT);
        end
    end

`ifdef PWM_DEC_PERIOD_EN
    logic                s_prev_r;
    logic                seen_edge_r;
    logic [PERIOD_W-1:0] per_cnt_r;
    logic [PERIOD_W-1:0] period_r;
    logic                period_valid_r;
    logic                rise_s;

    assign rise_s       = s_r & ~s_prev_r;
    assign period       = period_r;
    assign period_valid = period_valid_r;

    // Edge-to-edge period counter; no report for the first edge or a saturated count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_prev_r       <= 1'b0;
            seen_edge_r    <= 1'b0;
            per_cnt_r      <= 16'd0;
            period_r       <= 16'd0;
            period_valid_r <= 1'b0;
        end else begin
            s_prev_r <= s_r;
            if (rise_s) begin
                per_cnt_r   <= 16'd0;
                seen_edge_r <= 1'b1;
                if (seen_edge_r && (per_cnt_r != 16'hFFFF)) begin
                    period_r       <= per_cnt_r + 16'd1;
                    period_valid_r <= 1'b1;
                end else begin
                    period_valid_r <= 1'b0;
                end
            end else begin
                period_valid_r <= 1'b0;
                if (per_cnt_r != 16'hFFFF) begin
                    per_cnt_r <= per_cnt_r + 16'd1;
                end else begin
                    per_cnt_r <= per_cnt_r;
                end
            end
        end
    end
`else
    assign period       = {PERIOD_W{1'b0}};
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_audio_decoder.sv
// Scoreboard bench for pwm_audio_decoder (WIN_BITS=8, SILENCE_WINDOWS=4).
module tb_pwm_audio_decoder;
    import pwm_audio_decoder_pkg::*;

    typedef struct packed {
        logic [7:0] smp;
        logic       sil;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sound = 1'b0;
    logic        overrun;
    logic        silent;
    logic [15:0] period;
    logic        period_valid;

    int n_vec = 0;
    int n_err = 0;

    pwm_audio_decoder_if #(.WIN_BITS(8)) aud();

    pwm_audio_decoder #(
        .WIN_BITS       (8),
        .SILENCE_WINDOWS(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sound       (sound),
        .aud         (aud),
        .overrun     (overrun),
        .silent      (silent),
        .period      (period),
        .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: synchronizer delay, 256-cycle windows, silence tracking.
    exp_t       sb_q[$];
    logic       m_sync1 = 1'b0;
    logic       m_s = 1'b0;
    logic [7:0] m_win = 8'd0;
    logic [8:0] m_acc = 9'd0;
    logic [7:0] m_zc = 8'd0;
    logic       m_sil = 1'b1;
    int         cap_cnt = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_sync1 = 1'b0; m_s = 1'b0; m_win = 8'd0; m_acc = 9'd0;
                m_zc = 8'd0; m_sil = 1'b1;
                sb_q.delete();
            end else begin
                if (m_win == 8'd255) begin
                    logic [8:0] tot;
                    exp_t       e;
                    tot = m_acc + {8'd0, m_s};
                    e.smp = (tot >= 9'd256) ? 8'd255 : tot[7:0];
                    if (e.smp != 8'd0) begin
                        m_zc = 8'd0; m_sil = 1'b0;
                    end else begin
                        if (m_zc != 8'd255) m_zc = m_zc + 8'd1;
                        if (m_zc >= 8'd4) m_sil = 1'b1;
                    end
                    e.sil = m_sil;
                    sb_q.push_back(e);
                    m_acc = 9'd0;
                    cap_cnt++;
                end else begin
                    m_acc = m_acc + {8'd0, m_s};
                end
                m_win = m_win + 8'd1;
                m_s = m_sync1;
                m_sync1 = sound;
            end
        end
    end

    // Consumer side: compare each capture against the model one cycle later.
    int   zero_run = 0;
    logic prev_sil = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                zero_run = 0;
                prev_sil = 1'b1;
            end else if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sample", {24'd0, aud.sample}, {24'd0, e.smp});
                check_val("valid_on_capture", {31'd0, aud.sample_valid}, 32'd1);
                check_val("silent", {31'd0, silent}, {31'd0, e.sil});
                if (aud.sample == 8'd0) zero_run++;
                else zero_run = 0;
                if (silent && !prev_sil) check_val("silent_at_4th_zero", zero_run, 32'd4);
                prev_sil = silent;
            end
        end
    end

    int pat = 0;

    // mode 0: low, 1: high, 2: one high / three low
    task automatic step(input int mode);
        case (mode)
            0: sound = 1'b0;
            1: sound = 1'b1;
            default: begin
                sound = (pat == 0);
                pat = (pat + 1) % 4;
            end
        endcase
        @(negedge clk);
    endtask

    task automatic run(input int n, input int mode);
        int pv_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(mode);
`ifdef PWM_DEC_PERIOD_EN
            if (mode == 2 && i >= 16 && period_valid) begin
                pv_cnt++;
                check_val("period", {16'd0, period}, 32'd4);
            end
`endif
        end
`ifdef PWM_DEC_PERIOD_EN
        if (mode == 2 && n == 800) check_val("period_valid_count", pv_cnt, 32'd196);
`else
        if (mode == 2) check_val("period_tied_off", {15'd0, period_valid, period}, 32'd0);
`endif
    endtask

    task automatic wait_caps(input int target, input int mode);
        for (int i = 0; i < 700 && cap_cnt < target; i++) step(mode);
        check_val("capture_wait", cap_cnt, target);
    endtask

    initial begin
        int t;
        int lat;
        aud.sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_sample", {24'd0, aud.sample}, 32'd0);
        check_val("rst_valid", {31'd0, aud.sample_valid}, 32'd0);
        check_val("rst_overrun", {31'd0, overrun}, 32'd0);
        check_val("rst_silent", {31'd0, silent}, 32'd1);
        check_val("rst_period", {15'd0, period_valid, period}, 32'd0);
        reset = 1'b1;

        run(800, 0);
        check_val("idle_silent", {31'd0, silent}, 32'd1);
        run(800, 1);
        check_val("full_scale", {24'd0, aud.sample}, 32'd255);
        check_val("tone_active", {31'd0, silent}, 32'd0);
        run(800, 2);
        check_val("quarter_duty", {24'd0, aud.sample}, 32'd64);

        aud.sample_ready = 1'b0;
        t = cap_cnt;
        wait_caps(t + 1, 2);
        check_val("first_no_overrun", {31'd0, overrun}, 32'd0);
        wait_caps(t + 2, 2);
        check_val("ovr_valid", {31'd0, aud.sample_valid}, 32'd1);
        check_val("ovr_flag", {31'd0, overrun}, 32'd1);
        check_val("ovr_sample", {24'd0, aud.sample}, 32'd64);
        step(2);
        check_val("ovr_hold", {31'd0, overrun}, 32'd1);
        aud.sample_ready = 1'b1;
        step(2);
        check_val("ovr_cleared", {31'd0, overrun}, 32'd0);
        check_val("valid_cleared", {31'd0, aud.sample_valid}, 32'd0);

        run(768, 1);
        run(1792, 0);
        check_val("silence_reached", {31'd0, silent}, 32'd1);

        run(800, 1);
        for (int i = 0; i < 300 && m_win != 8'd100; i++) step(1);
        check_val("mid_window_pos", {24'd0, m_win}, 32'd100);
        reset = 1'b0;
        #1;
        check_val("midrst_sample", {24'd0, aud.sample}, 32'd0);
        check_val("midrst_valid", {31'd0, aud.sample_valid}, 32'd0);
        check_val("midrst_overrun", {31'd0, overrun}, 32'd0);
        check_val("midrst_silent", {31'd0, silent}, 32'd1);
        check_val("midrst_period", {15'd0, period_valid, period}, 32'd0);
        step(1);
        step(1);
        reset = 1'b1;
        lat = 0;
        for (int i = 0; i < 400 && !aud.sample_valid; i++) begin
            step(1);
            lat++;
        end
        check_val("post_reset_latency", lat, 32'd256);
        check_val("post_reset_full_window", {24'd0, aud.sample}, 32'd254);
        run(10, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
